load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Clock/reset: one clock; reset is asynchronous and active-low. The unit SHALL use port clk (rising edge) and port rst_n (asynchronous, active-low).
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 req_valid  in  1  datapath request strobe.
REQ-005 req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-006 req_store  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load result.
REQ-013 resp_err  out  1  error flag, qualified by resp_valid.
REQ-014 MemAddress  out  32  word-aligned address to DataMemory.
REQ-015 MemWriteData  out  32  write word to DataMemory.
REQ-016 MemWrite  out  1  write strobe; memory writes on the rising clk edge.
REQ-017 MemRead  out  1  read enable.
REQ-018 MemReadData  in  32  combinational read data, valid in any cycle with MemRead=1.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-020 On accept, the unit SHALL latch all req_* fields and ignore req_* inputs until it returns to IDLE.
REQ-021 An error SHALL be flagged on accept for any of: size=11, half with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 Accept transitions SHALL be: error -> DONE; load -> READ; word store -> WRITE; byte/half store -> READ (read-modify-write).
REQ-023 READ: MemRead=1 and MemAddress={addr[31:2],2'b00}; MemReadData SHALL be registered on the exiting edge; load -> DONE, store -> WRITE.
REQ-024 WRITE: MemWrite=1 for exactly one cycle, same MemAddress; next state DONE.
REQ-025 Word store: MemWriteData SHALL equal wdata.
REQ-026 Byte store: MemWriteData SHALL equal the registered word with lane addr[1:0] replaced by wdata[7:0].
REQ-027 Half store: MemWriteData SHALL equal the registered word with lanes {addr[1],0}/{addr[1],1} replaced by wdata[15:0].
REQ-028 Byte ordering SHALL be little-endian: lane 0 = bits[7:0].
REQ-029 DONE: resp_valid=1 for one cycle with resp_err per REQ-021; next state IDLE.
REQ-030 Load result: the selected byte/half SHALL be extended per req_unsigned, or the full word used for word loads.
REQ-031 resp_rdata SHALL be updated only on a load response, as the extended load result; it SHALL hold otherwise, including across store and error responses.
REQ-032 An error SHALL produce no MemRead or MemWrite assertion.
REQ-033 Latency from accept edge to resp_valid:
  - word/byte/half load: 2 cycles
  - word store: 2 cycles
  - byte/half store: 3 cycles
  - error: 1 cycle
REQ-034 MemRead and MemWrite SHALL never be high in the same cycle and SHALL be low in IDLE and DONE.
REQ-035 MemAddress and MemWriteData SHALL be 0 when their strobe is low.
REQ-036 req_valid held high across consecutive requests SHALL start the next access on the first edge after returning to IDLE; there are no back-to-back accepts.

Reset
REQ-037 While rst_n=0, the unit SHALL be in state IDLE, with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, MemAddress=0 and MemWriteData=0.
REQ-038 Reset asserted mid-access SHALL drop the strobes immediately and return to IDLE; no write SHALL occur, and no response SHALL be issued for the aborted request.

Verification
REQ-039 Word store then load: store addr 0x04, data 0xAAAAAAAA -> MemWrite pulse 1 cycle at 0x04 and resp_valid 2 cycles after accept; then load word 0x04 -> resp_rdata=0xAAAAAAAA.
REQ-040 Byte RMW: memory[0x08]=0x11223344; store byte 0x0A, data 0xEE -> READ then WRITE of 0x11EE3344; load byte signed 0x0A -> resp_rdata=0xFFFFFFEE; unsigned -> 0x000000EE.
REQ-041 Half load: memory[0x0C]=0x8001F00D; load half signed 0x0E -> 0xFFFF8001; load half unsigned 0x0C -> 0x0000F00D.
REQ-042 Errors: load word 0x05, store half 0x03, size=11 -> each gives resp_valid with resp_err=1 1 cycle after accept, no strobes, and resp_rdata unchanged.
REQ-043 Reset during the READ of a byte store -> strobes low asynchronously, memory word unchanged, no resp_valid, req_ready=1.
REQ-044 req_valid held high for 3 word loads -> accepts spaced 3 cycles apart, and req_ready=0 outside IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a single-port DataMemory with combinational reads.
// Sub-word stores are handled as a read-modify-write of the containing word.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  state_t      stateReg, stateNext;

  logic        storeReg;
  logic [1:0]  sizeReg;
  logic        unsignedReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic        errReg;
  logic [31:0] readWordReg;
  logic [31:0] respRdataReg;

  logic        accept;
  logic        reqErr;
  logic [31:0] wordAddr;
  logic [31:0] mergedWord;
  logic [31:0] storeWord;
  logic [3:0][7:0] memLane;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadResult;

  assign accept = req_valid && (stateReg == IDLE);

  // Misaligned or reserved-size requests never touch memory.
  assign reqErr = (req_size == SizeRsvd) ||
                  ((req_size == SizeHalf) && req_addr[0]) ||
                  ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));

  assign wordAddr = {addrReg[31:2], 2'b00};

  // Per-lane merge of store data into the word captured during READ.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       laneHit;
      logic [7:0] laneData;

      assign laneHit  = (sizeReg == SizeByte) ? (addrReg[1:0] == LANE)
                                              : (addrReg[1] == LANE[1]);
      assign laneData = ((sizeReg == SizeHalf) && LANE[0]) ? wdataReg[15:8]
                                                           : wdataReg[7:0];
      assign mergedWord[8*gi +: 8] = laneHit ? laneData : readWordReg[8*gi +: 8];
      assign memLane[gi] = MemReadData[8*gi +: 8];
    end
  endgenerate

  assign storeWord = (sizeReg == SizeWord) ? wdataReg : mergedWord;

  assign byteSel = memLane[addrReg[1:0]];
  assign halfSel = addrReg[1] ? MemReadData[31:16] : MemReadData[15:0];

  always_comb begin
    loadResult = MemReadData;
    case (sizeReg)
      SizeByte: loadResult = {{24{~unsignedReg & byteSel[7]}}, byteSel};
      SizeHalf: loadResult = {{16{~unsignedReg & halfSel[15]}}, halfSel};
      default:  loadResult = MemReadData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemAddress   = 32'd0;
    MemWriteData = 32'd0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (reqErr) begin
            stateNext = DONE;
          end else if (!req_store) begin
            stateNext = READ;
          end else if (req_size == SizeWord) begin
            stateNext = WRITE;
          end else begin
            stateNext = READ;
          end
        end
      end
      READ: begin
        MemRead    = 1'b1;
        MemAddress = wordAddr;
        stateNext  = storeReg ? WRITE : DONE;
      end
      WRITE: begin
        MemWrite     = 1'b1;
        MemAddress   = wordAddr;
        MemWriteData = storeWord;
        stateNext    = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = errReg;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      storeReg    <= 1'b0;
      sizeReg     <= 2'b00;
      unsignedReg <= 1'b0;
      addrReg     <= 32'd0;
      wdataReg    <= 32'd0;
      errReg      <= 1'b0;
    end else if (accept) begin
      storeReg    <= req_store;
      sizeReg     <= req_size;
      unsignedReg <= req_unsigned;
      addrReg     <= req_addr;
      wdataReg    <= req_wdata;
      errReg      <= reqErr;
    end
  end

  // The load result lands on the READ exit edge so it is already valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readWordReg  <= 32'd0;
      respRdataReg <= 32'd0;
    end else if (stateReg == READ) begin
      readWordReg <= MemReadData;
      if (!storeReg) begin
        respRdataReg <= loadResult;
      end
    end
  end

  assign resp_rdata = respRdataReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a cycle-level expectation queue built from the
// request rules, a bench-side memory, and literal checks on the documented scenarios.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  // DataMemory the DUT talks to, plus the reference copy the model keeps.
  logic [31:0] mem    [16];
  logic [31:0] refMem [16];

  assign MemReadData = MemRead ? mem[MemAddress[5:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One entry per busy cycle after an accept; an empty queue means an idle cycle.
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rv;
    bit          err;
    logic [31:0] rdata;
    bit          setRdata;
  } cyc_t;

  cyc_t        expQ[$];
  bit          idleNow = 1'b1;
  logic [31:0] modelRdata = 32'd0;
  longint      acceptTimes[$];

  function automatic cyc_t mk(bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                              bit rv, bit err, logic [31:0] rdata, bit setR);
    cyc_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = d;
    c.rv = rv; c.err = err; c.rdata = rdata; c.setRdata = setR;
    return c;
  endfunction

  // Model: on every accept, derive the whole expected cycle sequence from the request.
  logic [31:0] mA, mWa, mOld, mV, mMask, mNew;
  int          mSh;
  bit          mErr;
  always @(posedge clk) begin
    if (rst_n && req_valid && idleNow) begin
      acceptTimes.push_back($time);
      mA   = req_addr;
      mWa  = mA & 32'hFFFF_FFFC;
      mSh  = int'(mA[1:0]) * 8;
      mOld = refMem[mA[5:2]];
      mErr = (req_size == 2'b11) || (req_size == 2'b01 && mA[0]) ||
             (req_size == 2'b10 && mA[1:0] != 2'b00);
      if (mErr) begin
        expQ.push_back(mk(0, 0, 0, 0, 1, 1, modelRdata, 0));
      end else if (!req_store) begin
        if (req_size == 2'b00) begin
          mV = (mOld >> mSh) & 32'hFF;
          if (!req_unsigned && mV[7]) mV = mV | 32'hFFFF_FF00;
        end else if (req_size == 2'b01) begin
          mV = (mOld >> mSh) & 32'hFFFF;
          if (!req_unsigned && mV[15]) mV = mV | 32'hFFFF_0000;
        end else begin
          mV = mOld;
        end
        expQ.push_back(mk(1, 0, mWa, 0, 0, 0, modelRdata, 0));
        expQ.push_back(mk(0, 0, 0, 0, 1, 0, mV, 1));
      end else if (req_size == 2'b10) begin
        expQ.push_back(mk(0, 1, mWa, req_wdata, 0, 0, modelRdata, 0));
        expQ.push_back(mk(0, 0, 0, 0, 1, 0, modelRdata, 0));
      end else begin
        mMask = (req_size == 2'b00) ? (32'hFF << mSh) : (32'hFFFF << mSh);
        mNew  = (mOld & ~mMask) | ((req_wdata << mSh) & mMask);
        expQ.push_back(mk(1, 0, mWa, 0, 0, 0, modelRdata, 0));
        expQ.push_back(mk(0, 1, mWa, mNew, 0, 0, modelRdata, 0));
        expQ.push_back(mk(0, 0, 0, 0, 1, 0, modelRdata, 0));
      end
    end
  end

  // Compare every cycle, mid-cycle, against the model's expectation.
  cyc_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      idleNow    = 1'b1;
      modelRdata = 32'd0;
      check("rst.req_ready", req_ready, 1);
      check("rst.resp_valid", resp_valid, 0);
      check("rst.resp_err", resp_err, 0);
      check("rst.resp_rdata", resp_rdata, 0);
      check("rst.MemRead", MemRead, 0);
      check("rst.MemWrite", MemWrite, 0);
      check("rst.MemAddress", MemAddress, 0);
      check("rst.MemWriteData", MemWriteData, 0);
    end else if (expQ.size() == 0) begin
      idleNow = 1'b1;
      check("idle.req_ready", req_ready, 1);
      check("idle.resp_valid", resp_valid, 0);
      check("idle.MemRead", MemRead, 0);
      check("idle.MemWrite", MemWrite, 0);
      check("idle.MemAddress", MemAddress, 0);
      check("idle.MemWriteData", MemWriteData, 0);
      check("idle.resp_rdata", resp_rdata, modelRdata);
    end else begin
      e = expQ.pop_front();
      idleNow = 1'b0;
      check("busy.req_ready", req_ready, 0);
      check("busy.MemRead", MemRead, e.rd);
      check("busy.MemWrite", MemWrite, e.wr);
      check("busy.MemAddress", MemAddress, e.addr);
      check("busy.MemWriteData", MemWriteData, e.wdata);
      check("busy.resp_valid", resp_valid, e.rv);
      check("busy.resp_err", resp_err, e.err);
      check("busy.resp_rdata", resp_rdata, e.rdata);
      if (e.wr) refMem[e.addr[5:2]] = e.wdata;
      if (e.setRdata) modelRdata = e.rdata;
    end
  end

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check(name, req_ready, 1);
  endtask

  task automatic doReq(input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d; req_valid = 1'b1;
    waitReady("acceptTimeout");
    @(negedge clk);
    // Scramble the request fields; the DUT must be working from its latched copy.
    req_valid = 1'b0; req_store = ~st; req_size = 2'b11; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_F00D;
    waitReady("respTimeout");
    $display("req store=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h",
             st, sz, uns, a, d, resp_rdata);
  endtask

  int base;
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h0101_0101 * i;
      refMem[i] = 32'h0101_0101 * i;
    end
    mem[2] = 32'h1122_3344; refMem[2] = 32'h1122_3344;
    mem[3] = 32'h8001_F00D; refMem[3] = 32'h8001_F00D;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    doReq(1, 2'b10, 0, 32'h04, 32'hAAAA_AAAA);
    check("wordStore.mem", mem[1], 32'hAAAA_AAAA);
    doReq(0, 2'b10, 0, 32'h04, 32'h0);
    check("wordLoad.rdata", resp_rdata, 32'hAAAA_AAAA);

    doReq(1, 2'b00, 0, 32'h0A, 32'h1234_56EE);
    check("byteRmw.mem", mem[2], 32'h11EE_3344);
    doReq(0, 2'b00, 0, 32'h0A, 32'h0);
    check("byteLoadSigned", resp_rdata, 32'hFFFF_FFEE);
    doReq(0, 2'b00, 1, 32'h0A, 32'h0);
    check("byteLoadUnsigned", resp_rdata, 32'h0000_00EE);

    doReq(0, 2'b01, 0, 32'h0E, 32'h0);
    check("halfLoadSigned", resp_rdata, 32'hFFFF_8001);
    doReq(0, 2'b01, 1, 32'h0C, 32'h0);
    check("halfLoadUnsigned", resp_rdata, 32'h0000_F00D);

    doReq(1, 2'b01, 0, 32'h0E, 32'h5555_BEEF);
    check("halfRmw.mem", mem[3], 32'hBEEF_F00D);
    doReq(1, 2'b00, 0, 32'h0C, 32'h0000_0077);
    check("byteLane0.mem", mem[3], 32'hBEEF_F077);

    doReq(0, 2'b10, 0, 32'h05, 32'h0);
    check("errLoadWord.rdata", resp_rdata, 32'h0000_F00D);
    doReq(1, 2'b01, 0, 32'h03, 32'h1234_5678);
    check("errStoreHalf.mem", mem[0], 32'h0000_0000);
    doReq(0, 2'b11, 0, 32'h08, 32'h0);
    check("errSize.rdata", resp_rdata, 32'h0000_F00D);

    // req_valid held high across three word loads.
    base = acceptTimes.size();
    @(negedge clk);
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h04; req_wdata = 32'h0; req_valid = 1'b1;
    for (int n = 0; n < 40 && acceptTimes.size() < base + 3; n++) @(negedge clk);
    req_valid = 1'b0;
    check("heldValid.accepts", acceptTimes.size() - base, 3);
    if (acceptTimes.size() >= base + 3) begin
      check("heldValid.gap1", 32'((acceptTimes[base+1] - acceptTimes[base]) / 10), 3);
      check("heldValid.gap2", 32'((acceptTimes[base+2] - acceptTimes[base+1]) / 10), 3);
    end
    waitReady("heldValid.respTimeout");
    $display("held req_valid: 3 word loads at 0x04 -> rdata=%h", resp_rdata);
    check("heldValid.rdata", resp_rdata, 32'hAAAA_AAAA);

    // Reset asserted during the READ of a byte store.
    @(negedge clk);
    req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h0000_0099; req_valid = 1'b1;
    @(posedge clk);
    #2;
    check("abort.inRead", MemRead, 1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort.MemRead", MemRead, 0);
    check("abort.MemWrite", MemWrite, 0);
    check("abort.MemAddress", MemAddress, 0);
    check("abort.req_ready", req_ready, 1);
    check("abort.resp_valid", resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort.memUnchanged", mem[2], 32'h11EE_3344);
    $display("abort byte store at 0x09 -> mem[0x08]=%h", mem[2]);

    doReq(0, 2'b00, 1, 32'h0A, 32'h0);
    check("afterAbort.byteLoad", resp_rdata, 32'h0000_00EE);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
